// File: rtl/ev_motor_ramp_ctrl.sv
// ev_motor_ramp_ctrl
//   EV traction motor controller: turns accelerator/brake pedal levels into a
//   ramp-limited PWM duty, with a pedal-conflict fault latch and optional
//   regenerative-brake outputs.
//
// Optional feature macro: EV_MOTOR_REGEN_BRAKE_EN
//   defined   -> regen_out / regen_level are registered and active in BRAKE
//   undefined -> regen_out / regen_level are tied to 0, no regen logic
//
// Ports
//   clk          in   rising-edge clock for all state
//   rst_n        in   synchronous active-low reset
//   ena          in   tile enable; low behaves exactly like rst_n low
//   power_en     in   system power request; low forces OFF
//   accel        in   [DATA_W]  accelerator pedal level
//   brake        in   [DATA_W]  brake pedal level
//   pwm_out      out  registered motor PWM
//   duty         out  [PWM_W]   current ramped duty
//   state        out  [3]       OFF=0 IDLE=1 DRIVE=2 BRAKE=3 FAULT=4
//   fault        out  high while in FAULT
//   regen_out    out  regenerative-brake enable
//   regen_level  out  [PWM_W]   regenerative-brake strength
module ev_motor_ramp_ctrl #(
    parameter int DATA_W    = 4,
    parameter int PWM_W     = 8,
    parameter int RAMP_DIV  = 4,
    parameter int RAMP_STEP = 8,
    parameter int FAULT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              power_en,
    input  logic [DATA_W-1:0] accel,
    input  logic [DATA_W-1:0] brake,
    output logic              pwm_out,
    output logic [PWM_W-1:0]  duty,
    output logic [2:0]        state,
    output logic              fault,
    output logic              regen_out,
    output logic [PWM_W-1:0]  regen_level
);

    generate
        if (PWM_W < DATA_W) begin : g_bad_pwm_w
            $error("ev_motor_ramp_ctrl: PWM_W must be >= DATA_W");
        end
        if (RAMP_DIV < 1) begin : g_bad_ramp_div
            $error("ev_motor_ramp_ctrl: RAMP_DIV must be >= 1");
        end
    endgenerate

    localparam int SHIFT = PWM_W - DATA_W;
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int FC_W  = $clog2(FAULT_CYC + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FAULT_CYC - 1);
    localparam logic [PWM_W:0]   STEP1    = (PWM_W + 1)'(RAMP_STEP);
    localparam logic [PWM_W:0]   STEP2    = (PWM_W + 1)'(2 * RAMP_STEP);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_BRAKE = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t            cur_state, next_state;
    logic [PRE_W-1:0]  presc;
    logic [FC_W-1:0]   conf_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  shadow;
    logic [PWM_W-1:0]  shadow_next;
    logic [PWM_W-1:0]  target;
    logic [PWM_W-1:0]  duty_ramp;
    logic [DATA_W-1:0] pedal_diff;
    logic [PWM_W:0]    duty_x, tgt_x;
    logic              active, tick, conflict, conf_hit, reset_now;

    assign reset_now  = !rst_n || !ena;
    assign state      = cur_state;

    // Subtraction only used when accel > brake, so it never wraps.
    assign pedal_diff = accel - brake;
    assign target     = (accel > brake) ? (PWM_W'(pedal_diff) << SHIFT) : '0;
    assign duty_x     = {1'b0, duty};
    assign tgt_x      = {1'b0, target};

    assign active   = (cur_state == ST_IDLE) || (cur_state == ST_DRIVE) ||
                      (cur_state == ST_BRAKE);
    assign tick     = active && (presc == PRE_LAST);
    assign conflict = (&accel) && (&brake);
    // This cycle is the FAULT_CYC-th consecutive conflicting one.
    assign conf_hit = active && conflict && (conf_cnt == FC_LAST);

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_OFF: begin
                if (power_en) next_state = ST_IDLE;
            end
            ST_IDLE, ST_DRIVE, ST_BRAKE: begin
                if (!power_en)                          next_state = ST_OFF;
                else if (conf_hit)                      next_state = ST_FAULT;
                else if ((brake != '0) && (brake >= accel)) next_state = ST_BRAKE;
                else if (accel > brake)                 next_state = ST_DRIVE;
                else                                    next_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (!power_en) next_state = ST_OFF;
            end
            default: next_state = ST_OFF;
        endcase
    end

    // Ramp result applied on a tick; steps are clamped to land on the target.
    always_comb begin
        duty_ramp = duty;
        case (cur_state)
            ST_DRIVE: begin
                if (tgt_x > duty_x)
                    duty_ramp = ((tgt_x - duty_x) > STEP1) ? PWM_W'(duty_x + STEP1) : target;
                else if (tgt_x < duty_x)
                    duty_ramp = ((duty_x - tgt_x) > STEP1) ? PWM_W'(duty_x - STEP1) : target;
            end
            ST_IDLE:  duty_ramp = (duty_x > STEP1) ? PWM_W'(duty_x - STEP1) : '0;
            ST_BRAKE: duty_ramp = (duty_x > STEP2) ? PWM_W'(duty_x - STEP2) : '0;
            default:  duty_ramp = duty;
        endcase
    end

    // pwm_out compares against the shadow value that will hold for this
    // counter slot, so the period starting at counter 0 already uses the
    // freshly latched duty.
    always_comb begin
        shadow_next = shadow;
        if (next_state == ST_FAULT) shadow_next = '0;
        else if (pwm_cnt == '0)     shadow_next = duty;
    end

    always_ff @(posedge clk) begin
        if (reset_now) begin
            cur_state <= ST_OFF;
            presc     <= '0;
            conf_cnt  <= '0;
            pwm_cnt   <= '0;
            shadow    <= '0;
            duty      <= '0;
            pwm_out   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur_state <= next_state;
            pwm_cnt   <= pwm_cnt + 1'b1;
            presc     <= (active && !tick) ? presc + 1'b1 : '0;
            conf_cnt  <= (active && conflict) ? conf_cnt + 1'b1 : '0;
            shadow    <= shadow_next;
            pwm_out   <= (pwm_cnt < shadow_next);
            fault     <= (next_state == ST_FAULT);
            if ((next_state == ST_OFF) || (next_state == ST_FAULT))
                duty <= '0;
            else if (tick)
                duty <= duty_ramp;
        end
    end

`ifdef EV_MOTOR_REGEN_BRAKE_EN
    always_ff @(posedge clk) begin
        if (reset_now) begin
            regen_out   <= 1'b0;
            regen_level <= '0;
        end else if (next_state == ST_BRAKE) begin
            regen_out   <= 1'b1;
            regen_level <= PWM_W'(brake) << SHIFT;
        end else begin
            regen_out   <= 1'b0;
            regen_level <= '0;
        end
    end
`else
    assign regen_out   = 1'b0;
    assign regen_level = '0;
`endif

endmodule

// File: tb/tb_ev_motor_ramp_ctrl.sv
// Directed bench for ev_motor_ramp_ctrl with default parameters.
// Expected duty steps are queued as stimulus is applied and popped as the
// DUT's duty changes.
module tb_ev_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, ena, power_en;
    logic [3:0] accel, brake;
    logic       pwm_out, fault, regen_out;
    logic [7:0] duty, regen_level;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_chg = 0;
    logic [7:0] prev_duty = '0;
    logic [31:0] sb[$];

`ifdef EV_MOTOR_REGEN_BRAKE_EN
    localparam logic [31:0] EXP_REGEN_ON  = 32'd1;
    localparam logic [31:0] EXP_REGEN_LVL = 32'd192;
`else
    localparam logic [31:0] EXP_REGEN_ON  = 32'd0;
    localparam logic [31:0] EXP_REGEN_LVL = 32'd0;
`endif

    ev_motor_ramp_ctrl #(
        .DATA_W(4), .PWM_W(8), .RAMP_DIV(4), .RAMP_STEP(8), .FAULT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .power_en(power_en),
        .accel(accel), .brake(brake), .pwm_out(pwm_out), .duty(duty),
        .state(state), .fault(fault), .regen_out(regen_out),
        .regen_level(regen_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task step();
        @(negedge clk);
        cyc++;
        if (duty !== prev_duty) last_chg = cyc;
        prev_duty = duty;
    endtask

    task automatic ramp_watch(input string tag, input int budget);
        int last;
        logic [7:0] d0;
        logic [31:0] e;
        last = -1;
        d0 = duty;
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            step();
            if (duty !== d0) begin
                e = sb.pop_front();
                check(tag, duty, e);
                if (last >= 0) check({tag, "_interval"}, c - last, 4);
                last = c;
                d0 = duty;
            end
        end
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic align_tick();
        while (((cyc - last_chg) % 4) != 0) step();
    endtask

    task automatic wait_duty(input string tag, input logic [7:0] v, input int budget);
        int n;
        n = 0;
        while (duty !== v && n < budget) begin
            step();
            n++;
        end
        check({tag, "_reached"}, duty, v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_duty"}, duty, 0);
        check({tag, "_pwm"}, pwm_out, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_regen"}, regen_out, 0);
        check({tag, "_regen_lvl"}, regen_level, 0);
    endtask

    initial begin
        int highs, head, found;
        logic prev_pwm;

        rst_n = 1'b0; ena = 1'b1; power_en = 1'b0; accel = '0; brake = '0;
        step(); step();
        check_all_zero("reset");

        // Power up and ramp to 128.
        rst_n = 1'b1; power_en = 1'b1; accel = 4'd10; brake = 4'd2;
        step();
        check("off_to_idle", state, 1);
        step();
        check("idle_to_drive", state, 2);
        check("drive_start_duty", duty, 0);
        for (int i = 1; i <= 16; i++) sb.push_back(32'(8 * i));
        ramp_watch("ramp_up", 120);
        repeat (12) step();
        check("hold_duty", duty, 128);
        check("hold_state", state, 2);

        // DRIVE ramps downward toward a lower target.
        accel = 4'd6;
        for (int i = 1; i <= 8; i++) sb.push_back(32'(128 - 8 * i));
        ramp_watch("ramp_down_drive", 60);

        // PWM at duty 64, then a mid-period duty change.
        repeat (300) step();
        found = 0;
        prev_pwm = pwm_out;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step();
            if (pwm_out && !prev_pwm) found = 1;
            prev_pwm = pwm_out;
        end
        check("pwm_rise_found", found, 1);
        highs = 1; head = 1;
        for (int c = 1; c < 256; c++) begin
            if (c == 66) accel = 4'd10;
            step();
            if (pwm_out) begin
                highs++;
                if (c < 64) head++;
            end
        end
        check("pwm_p1_highs", highs, 64);
        check("pwm_p1_head", head, 64);
        step();
        check("pwm_p2_rise", pwm_out, 1);
        highs = 1;
        for (int c = 257; c < 512; c++) begin
            step();
            if (pwm_out) highs++;
        end
        check("pwm_p2_highs", highs, 128);
        check("pwm_p2_duty", duty, 128);

        // BRAKE: 16 per tick down to 0.
        align_tick();
        brake = 4'd12; accel = 4'd3;
        step();
        check("brake_state", state, 3);
        check("brake_regen_out", regen_out, EXP_REGEN_ON);
        check("brake_regen_lvl", regen_level, EXP_REGEN_LVL);
        for (int i = 1; i <= 8; i++) sb.push_back(32'(128 - 16 * i));
        ramp_watch("brake_ramp", 60);
        repeat (8) step();
        check("brake_floor", duty, 0);

        // Short DRIVE ramp, then IDLE decay.
        accel = 4'd4; brake = 4'd2;
        for (int i = 1; i <= 4; i++) sb.push_back(32'(8 * i));
        ramp_watch("ramp_small", 40);
        check("drive_regen_off", regen_out, 0);
        align_tick();
        accel = '0; brake = '0;
        step();
        check("idle_state", state, 1);
        for (int i = 1; i <= 4; i++) sb.push_back(32'(32 - 8 * i));
        ramp_watch("idle_decay", 30);

        // Pedal conflict: 15 cycles is tolerated, 16 faults.
        accel = 4'hF; brake = 4'hF;
        repeat (15) step();
        check("conflict15_state", state, 3);
        accel = '0; brake = '0;
        step();
        check("conflict15_release_state", state, 1);
        check("conflict15_fault", fault, 0);
        accel = 4'hF; brake = 4'hF;
        repeat (16) step();
        check("fault_state", state, 4);
        check("fault_flag", fault, 1);
        check("fault_pwm", pwm_out, 0);
        check("fault_duty", duty, 0);
        accel = '0; brake = '0;
        repeat (8) step();
        check("fault_sticky", state, 4);
        power_en = 1'b0;
        step();
        check("fault_exit_state", state, 0);
        check("fault_exit_flag", fault, 0);

        // Reset and enable mid-ramp.
        power_en = 1'b1; accel = 4'd10; brake = 4'd2;
        wait_duty("pre_rst", 8'd96, 200);
        rst_n = 1'b0;
        step();
        check_all_zero("mid_rst");
        rst_n = 1'b1;
        step();
        check("post_rst_state", state, 1);
        check("post_rst_duty", duty, 0);
        wait_duty("pre_ena", 8'd96, 200);
        ena = 1'b0;
        step();
        check_all_zero("ena_low");
        ena = 1'b1;

        // power_en drop clears duty on the same edge.
        wait_duty("pre_pwroff", 8'd64, 200);
        power_en = 1'b0;
        step();
        check("pwroff_state", state, 0);
        check("pwroff_duty", duty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ev_motor_ramp_ctrl.md
EV_MOTOR_RAMP_CTRL -- requirements
Module: ev_motor_ramp_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: width of the accelerator and brake pedal inputs.
REQ-002 Parameter PWM_W, default 8: width of the duty and PWM counter; the block SHALL require PWM_W >= DATA_W.
REQ-003 Parameter RAMP_DIV, default 4: clock cycles per ramp tick; the block SHALL require RAMP_DIV >= 1.
REQ-004 Parameter RAMP_STEP, default 8: maximum duty change per ramp tick.
REQ-005 Parameter FAULT_CYC, default 16: consecutive cycles of conflicting pedals before FAULT.
REQ-006 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port ena, input, 1: tile enable; low SHALL act exactly as rst_n low.
REQ-009 Port power_en, input, 1: system power request.
REQ-010 Port accel, input, DATA_W: accelerator pedal level.
REQ-011 Port brake, input, DATA_W: brake pedal level.
REQ-012 Port pwm_out, output, 1: registered motor PWM.
REQ-013 Port duty, output, PWM_W: current ramped duty.
REQ-014 Port state, output, 3: FSM state (OFF=0, IDLE=1, DRIVE=2, BRAKE=3, FAULT=4).
REQ-015 Port fault, output, 1: high while in FAULT.
REQ-016 Port regen_out, output, 1: regenerative-brake enable.
REQ-017 Port regen_level, output, PWM_W: regenerative-brake strength.

Function
REQ-018 Target: target = (accel - brake) << (PWM_W-DATA_W) when accel > brake, else 0.
REQ-019 The block SHALL compute the subtraction unsigned in DATA_W bits; it SHALL never underflow.
REQ-020 Any state except OFF SHALL go to OFF on the next edge when power_en = 0; duty SHALL clear to 0 in the same edge.
REQ-021 OFF SHALL go to IDLE when power_en = 1.
REQ-022 IDLE, DRIVE and BRAKE SHALL select the next state each cycle: brake != 0 and brake >= accel selects BRAKE; accel > brake selects DRIVE; otherwise the state SHALL be IDLE.
REQ-023 The block SHALL increment the prescaler every cycle outside OFF and FAULT and wrap it at RAMP_DIV-1; a ramp tick SHALL occur on the wrap cycle.
REQ-024 On a tick in DRIVE, duty SHALL move toward target by at most RAMP_STEP, without overshoot, in both directions.
REQ-025 On a tick in IDLE, duty SHALL decrease by RAMP_STEP, saturating at 0.
REQ-026 On a tick in BRAKE, duty SHALL decrease by 2*RAMP_STEP, saturating at 0.
REQ-027 The PWM counter SHALL be free-running at PWM_W bits and wrap from 2^PWM_W-1 to 0.
REQ-028 The block SHALL copy duty into a shadow register only when the counter equals 0, so no mid-period duty change appears on the output.
REQ-029 pwm_out SHALL be registered as (pwm_cnt < shadow); duty 0 SHALL give a constantly low output.
REQ-030 Pedal conflict: accel and brake both all-ones for FAULT_CYC consecutive cycles SHALL cause entry to FAULT; any break in the condition SHALL clear the count.
REQ-031 In FAULT, duty and shadow SHALL be 0 and pwm_out SHALL be 0 from the next cycle; FAULT SHALL exit only via power_en = 0 (to OFF).
REQ-032 Simultaneous power_en drop and fault condition: OFF SHALL win.

Reset
REQ-033 On reset, state, duty, shadow, pwm_out, counters, fault, regen_out and regen_level SHALL all be 0, on the next edge.
REQ-034 Reset mid-ramp SHALL abandon the ramp; after release the block SHALL be in OFF with duty 0.

Configuration
REQ-035 Macro EV_MOTOR_REGEN_BRAKE_EN defined: in BRAKE, regen_out = 1 and regen_level = brake << (PWM_W-DATA_W), both registered; both SHALL be 0 in other states.
REQ-036 Macro EV_MOTOR_REGEN_BRAKE_EN undefined: regen_out and regen_level SHALL be constant 0 and no regen logic SHALL be synthesised.

Verification (defaults)
REQ-037 Reset, then power_en=1, accel=10, brake=2 -> OFF to IDLE to DRIVE; duty rises 8 per 4 cycles and reaches 128 after 16 ticks, then holds at 128.
REQ-038 From duty 128, set brake=12, accel=3 -> BRAKE; duty falls 16 per tick and reaches 0 after 8 ticks; with the macro defined, regen_level=192.
REQ-039 duty=64 held -> pwm_out high for exactly 64 of every 256 cycles; a duty change mid-period SHALL take effect only at the next counter=0.
REQ-040 accel=brake=15 for 15 cycles, then release -> no fault; 16 cycles -> state=4, fault=1, pwm_out=0; then power_en=0 -> state=0.
REQ-041 rst_n=0 for one edge while duty=96 in DRIVE -> all outputs 0 and state=OFF the following cycle; ena=0 -> identical behaviour.
